// File: rtl/i2c_scl_clock.sv
// i2c_scl_clock: open-drain I2C SCL generator for a bus master.
// Divides clk_in down to the SCL rate, optionally synchronises to other
// masters pulling SCL low early, and flags a stuck-low bus via bus_clear.
`timescale 1ps/1ps
module i2c_scl_clock #(
  parameter int COUNTER_END  = 5,
  parameter int COUNTER_RISE = 2,
  parameter int MULTI_MASTER = 0,
  parameter int WAIT_END     = 100
) (
  input  logic clk_in,
  input  logic reset,
  inout  wire  scl,
  output logic bus_clear
);

  localparam int CW        = (COUNTER_END > 1) ? $clog2(COUNTER_END) : 1;
  localparam int LOW_LIMIT = WAIT_END + 2;
  localparam int LW        = $clog2(LOW_LIMIT + 1);

  // Initialisers match the reset values so an unconnected reset still starts cleanly.
  logic [CW-1:0] counter    = '0;
  logic [CW-1:0] counter_d;
  logic [LW-1:0] lowCount_q = '0;
  logic [LW-1:0] lowCount_d;
  logic          busClear_q = 1'b0;
  logic          busClear_d;
  logic          sclLow;

  // Low phase is driven, high phase is released to the bus pull-up.
  assign scl       = (counter < CW'(COUNTER_RISE)) ? 1'b0 : 1'bz;
  assign sclLow    = (scl == 1'b0);
  assign bus_clear = busClear_q;

  // Period counter: restart early when another master or device pulls SCL low
  // during our released phase, otherwise wrap at the end of the period.
  always_comb begin
    counter_d = counter + CW'(1);
    if ((MULTI_MASTER != 0) && (counter >= CW'(COUNTER_RISE)) && sclLow) begin
      counter_d = '0;
    end else if (counter == CW'(COUNTER_END - 1)) begin
      counter_d = '0;
    end
  end

  // Stuck-low detector: count consecutive low samples, saturating at the limit;
  // bus_clear is high exactly while the saturated count is held.
  always_comb begin
    lowCount_d = '0;
    busClear_d = 1'b0;
    if (sclLow) begin
      if (lowCount_q == LW'(LOW_LIMIT)) begin
        lowCount_d = lowCount_q;
      end else begin
        lowCount_d = lowCount_q + LW'(1);
      end
      if (lowCount_d == LW'(LOW_LIMIT)) begin
        busClear_d = 1'b1;
      end
    end
  end

  // State registers; reset abandons the current period and the stuck-low history.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      lowCount_q <= '0;
      busClear_q <= 1'b0;
    end else begin
      counter    <= counter_d;
      lowCount_q <= lowCount_d;
      busClear_q <= busClear_d;
    end
  end

endmodule

// File: tb/tb_i2c_scl_clock.sv
// tb_i2c_scl_clock: directed bench for i2c_scl_clock.
// dutA is multi-master, dutB free-running (both 5/2), dutC is 10/5 free-running.
`timescale 1ps/1ps
module tb_i2c_scl_clock;

  typedef struct {
    logic ext;
    int   cntA;
    logic sclA;
    int   cntB;
    logic sclB;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic extLow;
  wire  sclA;
  wire  sclB;
  wire  sclC;
  logic busClearA;
  logic busClearB;
  logic busClearC;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [29];

  pullup (sclA);
  pullup (sclB);
  pullup (sclC);

  // The external master / stuck device pulls both 5-cycle buses low together.
  assign sclA = extLow ? 1'b0 : 1'bz;
  assign sclB = extLow ? 1'b0 : 1'bz;

  // 4 ps clock: rising edges at 2, 6, 10 ... and falling edges at 4, 8, 12 ...
  always #2 clk = ~clk;

  i2c_scl_clock #(.COUNTER_END(5), .COUNTER_RISE(2), .MULTI_MASTER(1), .WAIT_END(100)) dutA (
    .clk_in(clk), .reset(reset), .scl(sclA), .bus_clear(busClearA));

  i2c_scl_clock #(.COUNTER_END(5), .COUNTER_RISE(2), .MULTI_MASTER(0), .WAIT_END(100)) dutB (
    .clk_in(clk), .reset(reset), .scl(sclB), .bus_clear(busClearB));

  i2c_scl_clock #(.COUNTER_END(10), .COUNTER_RISE(5), .MULTI_MASTER(0), .WAIT_END(100)) dutC (
    .clk_in(clk), .reset(reset), .scl(sclC), .bus_clear(busClearC));

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ext);
    extLow = ext;
  endtask

  // Starting on the falling edge where dutA restarts at 0, check n cycles of the 5/2 period.
  task automatic checkPeriodA(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("resume counterA", dutA.counter, i % 5);
      checkOutput("resume sclA", sclA, ((i % 5) >= 2) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  // Wait (bounded) for dutA's counter to show a given value on a falling edge.
  task automatic waitCounterA(input int value, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dutA.counter == 3'(value)) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    time  t0;

    vecs[0]  = '{1'b0, 0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0, 1, 1'b0, 1, 1'b0};
    vecs[2]  = '{1'b0, 2, 1'b1, 2, 1'b1};
    vecs[3]  = '{1'b0, 3, 1'b1, 3, 1'b1};
    vecs[4]  = '{1'b0, 4, 1'b1, 4, 1'b1};
    vecs[5]  = '{1'b0, 0, 1'b0, 0, 1'b0};
    vecs[6]  = '{1'b0, 1, 1'b0, 1, 1'b0};
    vecs[7]  = '{1'b0, 2, 1'b1, 2, 1'b1};
    vecs[8]  = '{1'b0, 3, 1'b1, 3, 1'b1};
    vecs[9]  = '{1'b0, 4, 1'b1, 4, 1'b1};
    vecs[10] = '{1'b0, 0, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b0, 1, 1'b0, 1, 1'b0};
    vecs[12] = '{1'b0, 2, 1'b1, 2, 1'b1};
    vecs[13] = '{1'b1, 3, 1'b0, 3, 1'b0};
    vecs[14] = '{1'b0, 0, 1'b0, 4, 1'b1};
    vecs[15] = '{1'b0, 1, 1'b0, 0, 1'b0};
    vecs[16] = '{1'b0, 2, 1'b1, 1, 1'b0};
    vecs[17] = '{1'b0, 3, 1'b1, 2, 1'b1};
    vecs[18] = '{1'b0, 4, 1'b1, 3, 1'b1};
    vecs[19] = '{1'b0, 0, 1'b0, 4, 1'b1};
    vecs[20] = '{1'b0, 1, 1'b0, 0, 1'b0};
    vecs[21] = '{1'b1, 2, 1'b0, 1, 1'b0};
    vecs[22] = '{1'b0, 0, 1'b0, 2, 1'b1};
    vecs[23] = '{1'b0, 1, 1'b0, 3, 1'b1};
    vecs[24] = '{1'b0, 2, 1'b1, 4, 1'b1};
    vecs[25] = '{1'b0, 3, 1'b1, 0, 1'b0};
    vecs[26] = '{1'b1, 4, 1'b0, 1, 1'b0};
    vecs[27] = '{1'b0, 0, 1'b0, 2, 1'b1};
    vecs[28] = '{1'b0, 1, 1'b0, 3, 1'b1};

    reset = 1'b1;
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset counterA", dutA.counter, 0);
    checkOutput("reset busClearA", busClearA, 0);
    checkOutput("reset sclA", sclA, 0);
    checkOutput("reset counterC", dutC.counter, 0);
    @(negedge clk);
    reset = 1'b0;

    // Free run, then early external lows at several released-phase counts.
    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i].ext);
      #1;
      checkOutput($sformatf("vec%0d counterA", i), dutA.counter, vecs[i].cntA);
      checkOutput($sformatf("vec%0d sclA", i), sclA, vecs[i].sclA);
      checkOutput($sformatf("vec%0d counterB", i), dutB.counter, vecs[i].cntB);
      checkOutput($sformatf("vec%0d sclB", i), sclB, vecs[i].sclB);
      checkOutput($sformatf("vec%0d busClearA", i), busClearA, 0);
      @(negedge clk);
    end
    applyStimulus(1'b0);

    // Stuck-low hold starting in dutA's low phase at count 0.
    waitCounterA(0, found);
    checkOutput("wait counterA 0", found, 1);
    applyStimulus(1'b1);
    t0 = $time;
    #400;
    checkOutput("busClearA at +400", busClearA, 0);
    #8;
    checkOutput("busClearA at +408", busClearA, 1);
    applyStimulus(1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (sclA === 1'b1) found = 1'b1;
    end
    checkOutput("sclA released after hold", found, 1);
    checkOutput("busClearA at release", busClearA, 1);
    #8;
    checkOutput("busClearA release +8", busClearA, 0);
    checkOutput("hold start time", ($time - t0) > 400 ? 1 : 0, 1);

    // Reset in the middle of a period.
    @(negedge clk);
    waitCounterA(3, found);
    checkOutput("wait counterA 3", found, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset counterA", dutA.counter, 0);
    checkOutput("midreset counterB", dutB.counter, 0);
    checkOutput("midreset busClearA", busClearA, 0);
    checkOutput("midreset sclA", sclA, 0);
    @(negedge clk);
    reset = 1'b0;
    checkPeriodA(10);

    // Reset while the bus is stuck low and bus_clear is flagged.
    applyStimulus(1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (busClearA === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("stuck busClearA set", found, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("stuckreset counterA", dutA.counter, 0);
    checkOutput("stuckreset busClearA", busClearA, 0);
    applyStimulus(1'b0);
    #1;
    checkOutput("stuckreset sclA driven", sclA, 0);
    @(negedge clk);
    reset = 1'b0;
    checkPeriodA(10);

    // 10/5 configuration: five cycles low, five released.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dutC.counter == 4'd0) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("wait counterC 0", found, 1);
    for (int i = 0; i < 20; i++) begin
      #1;
      checkOutput("counterC", dutC.counter, i % 10);
      checkOutput("sclC", sclC, ((i % 10) >= 5) ? 1 : 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
